// File: rtl/arm_regfile_mp_if.sv
// Port bundle for the multi-port ARM register file.
// Decode/write-back side is master; the register file is slave.
interface arm_regfile_mp_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 3
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [DATA_W-1:0]        pc_val;
    logic                     wr0_en;
    logic [ADDR_W-1:0]        wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [ADDR_W-1:0]        wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, rd_en, pc_val,
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output issue_en, issue_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, rd_en, pc_val,
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  issue_en, issue_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/arm_regfile_mp.sv
// Multi-port register file with write bypass, PC alias
// and a per-register busy scoreboard for RAW detection.
module arm_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 3
) (
    input logic             clk,
    input logic             rst,
    arm_regfile_mp_if.slave bus
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Per-register decode keeps every array index in range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= DATA_W'(r);
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.wr1_en && bus.wr1_addr == ADDR_W'(r))
                    regs[r] <= bus.wr1_data;
                else if (bus.wr0_en && bus.wr0_addr == ADDR_W'(r))
                    regs[r] <= bus.wr0_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (bus.flush)
                    busy[r] <= 1'b0;
                else if (bus.issue_en && bus.issue_addr == ADDR_W'(r))
                    busy[r] <= 1'b1;
                else if ((bus.wr0_en && bus.wr0_addr == ADDR_W'(r)) ||
                         (bus.wr1_en && bus.wr1_addr == ADDR_W'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

    assign bus.busy_vec = busy;

    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] arr_val;
    logic              arr_busy;
    logic              wb_hit;

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        a           = '0;
        arr_val     = '0;
        arr_busy    = 1'b0;
        wb_hit      = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            a        = bus.rd_addr[k*ADDR_W +: ADDR_W];
            arr_val  = bus.pc_val;
            arr_busy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (a == ADDR_W'(r)) begin
                    arr_val  = regs[r];
                    arr_busy = busy[r];
                end
            end
            wb_hit = (bus.wr0_en && bus.wr0_addr == a) ||
                     (bus.wr1_en && bus.wr1_addr == a);
            if (a >= ADDR_W'(NUM_REGS))
                bus.rd_data[k*DATA_W +: DATA_W] = bus.pc_val;
            else if (bus.wr1_en && bus.wr1_addr == a)
                bus.rd_data[k*DATA_W +: DATA_W] = bus.wr1_data;
            else if (bus.wr0_en && bus.wr0_addr == a)
                bus.rd_data[k*DATA_W +: DATA_W] = bus.wr0_data;
            else
                bus.rd_data[k*DATA_W +: DATA_W] = arr_val;
            // Out-of-range addresses never match, so arr_busy is 0 there.
            bus.rd_busy[k] = bus.rd_en[k] & arr_busy & ~wb_hit;
        end
    end
endmodule

// File: tb/tb_arm_regfile_mp.sv
// Table-driven bench for arm_regfile_mp: bypass, collision,
// dropped writes, scoreboard, flush and async reset.
module tb_arm_regfile_mp;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    arm_regfile_mp_if bus ();

    arm_regfile_mp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ra;
        logic        ren;
        logic        w0e;
        logic [3:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [3:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [3:0]  ia;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        logic        exp_rb;
        logic [14:0] exp_bv;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.rd_addr    = '0;
        bus.rd_en      = '0;
        bus.pc_val     = '0;
        bus.wr0_en     = 1'b0;
        bus.wr0_addr   = '0;
        bus.wr0_data   = '0;
        bus.wr1_en     = 1'b0;
        bus.wr1_addr   = '0;
        bus.wr1_data   = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
        bus.flush      = 1'b0;
    endtask

    function automatic vec_t mk(
        logic [3:0] ra, logic ren,
        logic w0e, logic [3:0] w0a, logic [31:0] w0d,
        logic w1e, logic [3:0] w1a, logic [31:0] w1d,
        logic ie, logic [3:0] ia, logic fl, logic [31:0] pc,
        logic [31:0] erd, logic erb, logic [14:0] ebv);
        vec_t v;
        v.ra = ra; v.ren = ren;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl; v.pc = pc;
        v.exp_rd = erd; v.exp_rb = erb; v.exp_bv = ebv;
        return v;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        //         ra ren w0e w0a w0d           w1e w1a w1d    ie ia fl pc       rd            rb bv
        tbl[0]  = mk(15,0, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h100, 32'h100,      0,15'h0);
        tbl[1]  = mk(3, 0, 1,3,32'hDEADBEEF,    0,0,32'h0,     0,0,0,32'h0,   32'hDEADBEEF, 0,15'h0);
        tbl[2]  = mk(3, 0, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h0,   32'hDEADBEEF, 0,15'h0);
        tbl[3]  = mk(5, 0, 1,5,32'h11,          1,5,32'h22,    0,0,0,32'h0,   32'h22,       0,15'h0);
        tbl[4]  = mk(5, 0, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h0,   32'h22,       0,15'h0);
        tbl[5]  = mk(15,0, 1,15,32'h55,         0,0,32'h0,     0,0,0,32'h200, 32'h200,      0,15'h0);
        tbl[6]  = mk(14,0, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h0,   32'd14,       0,15'h0);
        tbl[7]  = mk(2, 1, 0,0,32'h0,           0,0,32'h0,     1,2,0,32'h0,   32'd2,        0,15'h4);
        tbl[8]  = mk(2, 1, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h0,   32'd2,        1,15'h4);
        tbl[9]  = mk(2, 0, 0,0,32'h0,           0,0,32'h0,     0,0,0,32'h0,   32'd2,        0,15'h4);
        tbl[10] = mk(2, 1, 0,0,32'h0,           1,2,32'h77,    0,0,0,32'h0,   32'h77,       0,15'h0);
        tbl[11] = mk(2, 1, 1,2,32'h99,          0,0,32'h0,     1,2,0,32'h0,   32'h99,       0,15'h4);
        tbl[12] = mk(2, 1, 0,0,32'h0,           0,0,32'h0,     1,1,0,32'h0,   32'h99,       1,15'h6);
        tbl[13] = mk(2, 1, 0,0,32'h0,           0,0,32'h0,     1,4,0,32'h0,   32'h99,       1,15'h16);
        tbl[14] = mk(2, 1, 1,2,32'h33,          0,0,32'h0,     1,9,0,32'h0,   32'h33,       0,15'h212);
        tbl[15] = mk(9, 1, 0,0,32'h0,           0,0,32'h0,     1,6,1,32'h0,   32'd9,        1,15'h0);
        tbl[16] = mk(9, 1, 0,0,32'h0,           0,0,32'h0,     1,15,0,32'h0,  32'd9,        0,15'h0);
        tbl[17] = mk(8, 0, 1,8,32'hAA,          0,0,32'h0,     0,0,0,32'h0,   32'hAA,       0,15'h0);
        tbl[18] = mk(8, 0, 0,0,32'h0,           0,0,32'h0,     1,3,0,32'h0,   32'hAA,       0,15'h8);

        idle();
        rst = 1'b1;
        bus.rd_addr = {4'd14, 4'd7, 4'd0};
        #12;
        chk("rst_rd0", bus.rd_data[31:0], 32'd0);
        chk("rst_rd1", bus.rd_data[63:32], 32'd7);
        chk("rst_rd2", bus.rd_data[95:64], 32'd14);
        chk("rst_busy", 32'(bus.busy_vec), 32'h0);
        bus.rd_addr = {4'd0, 4'd0, 4'd15};
        bus.pc_val  = 32'h100;
        #1;
        chk("rst_pc", bus.rd_data[31:0], 32'h100);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 19; i++) begin
            idle();
            bus.rd_addr[3:0] = tbl[i].ra;
            bus.rd_en[0]     = tbl[i].ren;
            bus.wr0_en       = tbl[i].w0e;
            bus.wr0_addr     = tbl[i].w0a;
            bus.wr0_data     = tbl[i].w0d;
            bus.wr1_en       = tbl[i].w1e;
            bus.wr1_addr     = tbl[i].w1a;
            bus.wr1_data     = tbl[i].w1d;
            bus.issue_en     = tbl[i].ie;
            bus.issue_addr   = tbl[i].ia;
            bus.flush        = tbl[i].fl;
            bus.pc_val       = tbl[i].pc;
            #1;
            chk($sformatf("v%0d_rd", i), bus.rd_data[31:0], tbl[i].exp_rd);
            chk($sformatf("v%0d_rb", i), 32'(bus.rd_busy[0]),
                32'(tbl[i].exp_rb));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_bv", i), 32'(bus.busy_vec),
                32'(tbl[i].exp_bv));
        end

        // Mid-cycle async reset restores contents and clears busy.
        idle();
        bus.rd_addr = {4'd0, 4'd3, 4'd8};
        bus.rd_en   = 3'b010;
        #1;
        chk("pre_rst_r8", bus.rd_data[31:0], 32'hAA);
        chk("pre_rst_rb3", 32'(bus.rd_busy[1]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_r8", bus.rd_data[31:0], 32'd8);
        chk("arst_r3", bus.rd_data[63:32], 32'd3);
        chk("arst_busy", 32'(bus.busy_vec), 32'h0);
        chk("arst_rb", 32'(bus.rd_busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.rd_addr = {4'd5, 4'd2, 4'd8};
        #1;
        chk("post_r5", bus.rd_data[95:64], 32'd5);
        chk("post_r2", bus.rd_data[63:32], 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/arm_regfile_mp.md
# arm_regfile_mp

Parametrised multi-port register file for the ARM pipeline's decode stage, replacing the single-write, two-read register file. It provides NUM_RD combinational read ports with same-cycle write bypass, two prioritised write-back ports, a PC alias for the top address, and a per-register busy scoreboard. The scoreboard lets decode detect RAW hazards without a separate hazard unit.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 15, number of stored registers (R0..R(NUM_REGS-1))
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W > NUM_REGS
- NUM_RD, 3, number of read ports

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_en  in  NUM_RD  read-port valid; qualifies the hazard output only
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k reads a register with an outstanding write
- pc_val  in  DATA_W  value returned for any address >= NUM_REGS
- wr0_en, wr1_en  in  1  write-back enables
- wr0_addr, wr1_addr  in  ADDR_W  write-back destinations
- wr0_data, wr1_data  in  DATA_W  write-back data
- issue_en  in  1  an instruction with a register destination leaves decode
- issue_addr  in  ADDR_W  destination of the issued instruction
- flush  in  1  clear all busy bits; pipeline flush
- busy_vec  out  NUM_REGS  current scoreboard contents

## Operation
- Storage: regs[0..NUM_REGS-1], each DATA_W wide.
- Reset (async): regs[i] = i, zero-extended to DATA_W. busy_vec = 0. While rst is high, rd_data reflects the reset contents and rd_busy = 0.
- Write (posedge): a port with wrN_en=1 and wrN_addr < NUM_REGS writes its data. Writes to addresses >= NUM_REGS are silently dropped.
- Write collision: both ports enabled to the same address; wr1 wins.
- Read (combinational, per port k):
  - If rd_addr_k >= NUM_REGS, the port returns pc_val.
  - Else if wr1_en and wr1_addr == rd_addr_k, the port returns wr1_data.
  - Else if wr0_en and wr0_addr == rd_addr_k, the port returns wr0_data.
  - Else the port returns regs[rd_addr_k].
- Scoreboard (posedge), per register r, in decreasing priority:
  1. flush=1: busy[r] <= 0. Overrides issue and write-back in the same cycle.
  2. issue_en=1 and issue_addr == r: busy[r] <= 1. Set wins over a same-cycle clear, because the younger writer is still outstanding.
  3. A write-back to r on either port: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- issue_addr >= NUM_REGS never sets any busy bit (PC writes are handled by the branch path).
- rd_busy_k = rd_en_k & (rd_addr_k < NUM_REGS) & busy[rd_addr_k] & ~(write-back to rd_addr_k this cycle).
  - Bypassed data is valid, so a same-cycle write-back masks the hazard.
- Multiple writers in flight to one register are not tracked. A single busy bit per register is sufficient; the pipeline stalls on WAW before issue.

## Timing
- Read latency: 0 cycles, combinational from rd_addr, wr*, pc_val and regs.
- Write latency: 1 cycle. Data is visible in the array after the posedge, and via bypass before it.
- busy_vec and rd_busy reflect issue_en / flush 1 cycle later (registered). rd_busy also reacts combinationally to same-cycle write-back.
- Reset asserted mid-cycle immediately restores regs and busy, discarding any write pending at that edge.
- No handshake back-pressure; all inputs are sampled every posedge.

## Test plan
- Reset: pulse rst, then read addresses 0, 7, 14 -> rd_data = 0, 7, 14. Read address 15 with pc_val=0x100 -> 0x100. busy_vec = 0.
- Write and bypass:
  - wr0 writes 0xDEADBEEF to R3. Same cycle, rd_addr0=3 -> 0xDEADBEEF.
  - After the edge, with wr0_en=0 -> still 0xDEADBEEF.
- Collision: wr0 writes 0x11 and wr1 writes 0x22, both to R5 -> bypass read = 0x22, stored value after the edge = 0x22.
- Dropped write: wr0_addr=15 with data 0x55 -> regs unchanged. Read of address 15 still returns pc_val.
- Scoreboard:
  - issue R2 -> next cycle busy_vec[2]=1; with rd_en0=1, rd_addr0=2 -> rd_busy[0]=1.
  - wr1 writes R2 -> rd_busy[0]=0 in the same cycle, busy[2]=0 after the edge.
  - issue R2 and wr0 to R2 in the same cycle -> busy[2] stays 1.
- Flush and async reset:
  - Set busy on R1, R4, R9, then flush=1 together with issue R6 -> busy_vec = 0 after the edge.
  - Assert rst asynchronously between edges after writing R8=0xAA -> R8 reads 8 immediately.
